fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage.
- Owns the PC register and runs a request/acknowledge handshake to a variable-latency instruction memory.
- Presents instr_f and pc_plus_4_f, with a valid flag, to the IF/ID register.
- Accepts branch/jump redirects (PCSrc and target address) from decode, and honours stall from the hazard unit.

---
 rtl/fetch_stage.sv | 163 ++++++++++++++++
 tb/tb_fetch_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage.
// Owns the PC, runs a req/ack handshake to a variable-latency instruction
// memory and presents one instruction at a time to the IF/ID register.
// Optional macro FETCH_TIMEOUT_EN adds an ack watchdog (TIMEOUT_CYCLES) with a
// sticky imem_err flag; without it S_WAIT waits forever and imem_err is 0.
module fetch_stage #(
  parameter logic [31:0] RESET_PC       = 32'h0040_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_f,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_f,
  output logic [31:0] pc_plus_4_f,
  output logic        valid_f,
  output logic [31:0] pc_f,
  output logic        imem_err
);

  typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_FULL = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] tgt;
  logic [31:0] pc_inc;

  // Targets are word-aligned; low bits from decode are dropped.
  assign tgt    = {redirect_addr[31:2], 2'b00};
  assign pc_inc = pc_q + 32'd4;

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       timeout;
  // Fires on the TIMEOUT_CYCLES-th consecutive S_WAIT cycle without ack.
  assign timeout  = (cnt_q == 8'(TIMEOUT_CYCLES - 1));
  assign imem_err = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign imem_err = 1'b0;
`endif

  // Next-state logic for the fetch FSM and its datapath registers.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_REQ: begin
        state_d = S_WAIT;
`ifdef FETCH_TIMEOUT_EN
        cnt_d   = '0;
`endif
        // The request going out now is wrong-path; remember to drop its data.
        kill_d  = redirect_valid;
        if (redirect_valid) pc_d = tgt;
      end
      S_WAIT: begin
        if (imem_ack) begin
          if (kill_q || redirect_valid) begin
            kill_d  = 1'b0;
            if (redirect_valid) pc_d = tgt;
            state_d = S_REQ;
          end else begin
            instr_d = imem_rdata;
            pc4_d   = pc_inc;
            valid_d = 1'b1;
            pc_d    = pc_inc;
            state_d = S_FULL;
          end
        end else begin
          // Newest redirect wins; the outstanding data will be discarded.
          if (redirect_valid) begin
            pc_d   = tgt;
            kill_d = 1'b1;
          end
`ifdef FETCH_TIMEOUT_EN
          if (timeout) begin
            err_d   = 1'b1;
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
`endif
        end
      end
      S_FULL: begin
        if (redirect_valid) begin
          // Wrong-path instruction is dropped even under stall.
          valid_d = 1'b0;
          pc_d    = tgt;
          state_d = S_REQ;
        end else if (!stall_f) begin
          // Consumed this edge; the next request overlaps with the hand-off.
          valid_d = 1'b0;
          state_d = S_WAIT;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // State and datapath registers, asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Request strobe: S_REQ always, S_FULL only when the instruction is consumed.
  assign imem_req = rst_n &&
                    ((state_q == S_REQ) ||
                     (state_q == S_FULL && !redirect_valid && !stall_f));

  assign imem_addr   = pc_q;
  assign pc_f        = pc_q;
  assign instr_f     = instr_q;
  assign pc_plus_4_f = pc4_q;
  assign valid_f     = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage. The reference model is the
// architectural fetch stream: every instruction decode consumes must be the
// word at the latest redirect target (or RESET_PC), then successive +4 words.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_f = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr_f, pc_plus_4_f, pc_f;
  logic        valid_f, imem_err;

  int checks = 0;
  int errors = 0;
  int n_cons = 0;
  int mode = 1;  // memory: 0 random latency 1..3, 1 single-cycle, 2 mute

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall_f(stall_f),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_f(instr_f), .pc_plus_4_f(pc_plus_4_f), .valid_f(valid_f),
    .pc_f(pc_f), .imem_err(imem_err)
  );

  typedef struct packed { logic [31:0] pc4; logic [31:0] instr; } exp_t;
  exp_t exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RESET_PC) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic exp_t predict(input logic [31:0] pc);
    exp_t e;
    e.pc4   = pc + 32'd4;
    e.instr = mem_word(pc);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req_v, $time);
    end
  endtask

  // Memory model: answers each request after its latency, one at a time.
  initial begin : mem_proc
    logic [31:0] a;
    int lat;
    forever begin
      @(negedge clk);
      if (rst_n && imem_req && mode != 2) begin
        a   = imem_addr;
        lat = (mode == 0) ? int'($urandom_range(1, 3)) : 1;
        repeat (lat) @(posedge clk);
        #1 imem_ack = 1'b1; imem_rdata = mem_word(a);
        @(posedge clk);
        #1 imem_ack = 1'b0; imem_rdata = $urandom;
      end
    end
  end

  // Monitor: reset values, stall hold, redirect target, consumption scoreboard.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_instr, prev_pc4, prev_pc;
  logic        redir_pend = 1'b0;
  logic [31:0] redir_tgt;
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_valid", valid_f, 0);
      check("rst_instr", instr_f, 0);
      check("rst_pc4", pc_plus_4_f, 0);
      check("rst_pc", pc_f, RESET_PC);
      check("rst_err", imem_err, 0);
      check("rst_req", imem_req, 0);
      prev_hold  = 1'b0;
      redir_pend = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_instr", instr_f, prev_instr);
        check("hold_pc4", pc_plus_4_f, prev_pc4);
        check("hold_pc", pc_f, prev_pc);
      end
      if (imem_req) check("addr_align", {30'd0, imem_addr[1:0]}, 0);
      if (imem_req && redir_pend && !redirect_valid) begin
        check("redir_req_addr", imem_addr, redir_tgt);
        redir_pend = 1'b0;
      end
      if (redirect_valid) begin
        redir_pend = 1'b1;
        redir_tgt  = {redirect_addr[31:2], 2'b00};
      end
      if (valid_f && !redirect_valid) check("req_vs_stall", imem_req, !stall_f);
      if (valid_f && !stall_f && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard: consumed %h with empty queue", pc_plus_4_f);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("cons_instr", instr_f, e.instr);
          check("cons_pc4", pc_plus_4_f, e.pc4);
          exp_q.push_back(predict(e.pc4));
        end
        n_cons++;
      end
      prev_hold  = valid_f && stall_f && !redirect_valid;
      prev_instr = instr_f;
      prev_pc4   = pc_plus_4_f;
      prev_pc    = pc_f;
    end
  end

  task automatic do_redirect(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_addr  = a;
    exp_q.delete();
    exp_q.push_back(predict({a[31:2], 2'b00}));
  endtask

  // Stall, then wait (bounded) until an instruction is held in S_FULL.
  task automatic park();
    logic ok;
    ok = 1'b0;
    stall_f = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid_f) begin ok = 1'b1; break; end
    end
    check("park_valid", ok, 1);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [4:0] vpat, rpat;
    logic [31:0] a_to;
    exp_q.push_back(predict(RESET_PC));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Startup sequence with single-cycle memory.
    vpat = 5'b10100;
    rpat = 5'b10101;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("start_valid", valid_f, vpat[i]);
      check("start_req", imem_req, rpat[i]);
      if (i == 0) check("start_addr0", imem_addr, RESET_PC);
      if (i == 2) begin
        check("start_addr1", imem_addr, 32'h0040_0004);
        check("first_instr", instr_f, 32'h2008_0005);
        check("first_pc4", pc_plus_4_f, 32'h0040_0004);
      end
    end
    @(posedge clk); #1;

    // Stall three cycles in S_FULL, then release.
    park();
    repeat (3) @(posedge clk);
    #1 stall_f = 1'b0;
    @(negedge clk);
    check("resume_req", imem_req, 1);
    @(posedge clk); #1;

    // Redirect while full and stalled.
    park();
    do_redirect(32'h0040_0100);
    @(posedge clk);
    #1 redirect_valid = 1'b0; stall_f = 1'b0;
    @(negedge clk);
    check("redir_full_valid", valid_f, 0);
    check("redir_full_req", imem_req, 1);
    check("redir_full_addr", imem_addr, 32'h0040_0100);
    @(posedge clk); #1;

    // Redirect during S_WAIT; stale ack three cycles after the request.
    park();
    mode = 2;
    stall_f = 1'b0;
    @(posedge clk); #1 do_redirect(32'h0040_0200);
    @(negedge clk); check("wait_valid0", valid_f, 0);
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk); check("wait_valid1", valid_f, 0);
    @(posedge clk); #1 imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk); check("wait_valid2", valid_f, 0);
    @(posedge clk); #1 imem_ack = 1'b0;
    @(negedge clk);
    check("wait_drop_valid", valid_f, 0);
    check("wait_req", imem_req, 1);
    check("wait_req_addr", imem_addr, 32'h0040_0200);
    @(posedge clk); #1 imem_ack = 1'b1; imem_rdata = mem_word(32'h0040_0200); mode = 1;
    @(posedge clk); #1 imem_ack = 1'b0;

    // Reset in the middle of S_WAIT, stale ack right after release.
    park();
    mode = 2;
    stall_f = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    exp_q.delete();
    exp_q.push_back(predict(RESET_PC));
    @(posedge clk); #1 rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rst_req_addr", imem_addr, RESET_PC);
    check("rst_req_after", imem_req, 1);
    @(posedge clk); #1 imem_ack = 1'b0;
    @(negedge clk); check("rst_stale_valid", valid_f, 0);
    @(posedge clk); #1 imem_ack = 1'b1; imem_rdata = mem_word(RESET_PC); mode = 1;
    @(posedge clk); #1 imem_ack = 1'b0;
    @(negedge clk);
    check("rst_own_valid", valid_f, 1);
    check("rst_own_instr", instr_f, 32'h2008_0005);
    @(posedge clk); #1;

`ifdef FETCH_TIMEOUT_EN
    // Memory never answers: watchdog fires after four wait cycles.
    park();
    mode = 2;
    stall_f = 1'b0;
    @(negedge clk);
    a_to = imem_addr;
    check("to_req", imem_req, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("to_err_early", imem_err, 0);
      check("to_idle", imem_req, 0);
    end
    @(negedge clk);
    check("to_err", imem_err, 1);
    check("to_retry_req", imem_req, 1);
    check("to_retry_addr", imem_addr, a_to);
    @(posedge clk); #1 imem_ack = 1'b1; imem_rdata = mem_word(a_to); mode = 1;
    @(posedge clk); #1 imem_ack = 1'b0;
`endif

    // PC wrap: 0xFFFF_FFFC + 4 = 0 (low target bits dropped).
    park();
    do_redirect(32'hFFFF_FFFF);
    @(posedge clk);
    #1 redirect_valid = 1'b0; stall_f = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Randomized traffic: random latency, stalls and redirects.
    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      stall_f = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) do_redirect($urandom);
      else redirect_valid = 1'b0;
      @(posedge clk); #1;
    end
    redirect_valid = 1'b0;
    stall_f = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("consumed_enough", 32'(n_cons > 200), 1);
`ifdef FETCH_TIMEOUT_EN
    check("err_sticky", imem_err, 1);
`else
    check("err_tied", imem_err, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
